// File: rtl/serial_frame_pkg.sv
// rtl/serial_frame_pkg.sv - shared types and constants for the serial frame transmitter
package serial_frame_pkg;

    localparam int DATA_W_DEFAULT = 8;

    localparam int MODE_MSB_FIRST = 0;
    localparam int MODE_PARITY    = 1;

    localparam logic LINE_IDLE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

endpackage

// File: rtl/serial_frame_tx_if.sv
// rtl/serial_frame_tx_if.sv - byte handshake, baud strobe and line/status bundle
interface serial_frame_tx_if
    import serial_frame_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) ();

    logic              tx_valid;
    logic [DATA_W-1:0] tx_data;
    logic [1:0]        tx_mode;
    logic              bit_en;
    logic              tx_ready;
    logic              sdo;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] shadow;

    modport master (
        output tx_valid, tx_data, tx_mode, bit_en,
        input  tx_ready, sdo, busy, done, shadow
    );

    modport slave (
        input  tx_valid, tx_data, tx_mode, bit_en,
        output tx_ready, sdo, busy, done, shadow
    );

endinterface

// File: rtl/serial_frame_tx_shift_reg.sv
// rtl/serial_frame_tx_shift_reg.sv - data shift register with direction select and running parity
module tx_shift_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              msb_first,
    input  logic              shift_en,
    output logic              bit_out,
    output logic              next_bit,
    output logic              parity
);

    logic [DATA_W-1:0] sr_q;
    logic              par_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q  <= '0;
            par_q <= 1'b0;
        end else if (load) begin
            sr_q  <= load_data;
            par_q <= 1'b0;
        end else if (shift_en) begin
            par_q <= par_q ^ bit_out;
            if (msb_first) begin
                sr_q <= {sr_q[DATA_W-2:0], 1'b0};
            end else begin
                sr_q <= {1'b0, sr_q[DATA_W-1:1]};
            end
        end
    end

    assign bit_out  = msb_first ? sr_q[DATA_W-1] : sr_q[0];
    // Bit that will sit at the output end after the next shift.
    assign next_bit = msb_first ? sr_q[DATA_W-2] : sr_q[1];
    // Parity including the bit currently on the output end.
    assign parity   = par_q ^ bit_out;

endmodule

// File: rtl/serial_frame_tx.sv
// rtl/serial_frame_tx.sv - parallel-in serial-out frame transmitter (start, data, parity, stop)
module serial_frame_tx
    import serial_frame_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int CNT_W  = 4
) (
    input  logic             CK,
    input  logic             RST,
    serial_frame_tx_if.slave tx
);

    tx_state_e         state_q;
    tx_state_e         state_d;
    logic              sdo_q;
    logic              sdo_d;
    logic              done_q;
    logic              done_d;
    logic [DATA_W-1:0] shadow_q;
    logic [1:0]        mode_q;
    logic [CNT_W-1:0]  cnt_q;

    logic accept;
    logic period_end;
    logic shift_en;
    logic last_bit;
    logic sr_bit;
    logic sr_next_bit;
    logic sr_parity;

    assign accept     = tx.tx_valid && (state_q == ST_IDLE);
    assign period_end = tx.bit_en && (state_q != ST_IDLE);
    assign shift_en   = period_end && (state_q == ST_DATA);
    assign last_bit   = (cnt_q == CNT_W'(DATA_W - 1));

    tx_shift_reg #(
        .DATA_W (DATA_W)
    ) u_shift (
        .clk       (CK),
        .rst       (RST),
        .load      (accept),
        .load_data (tx.tx_data),
        .msb_first (mode_q[MODE_MSB_FIRST]),
        .shift_en  (shift_en),
        .bit_out   (sr_bit),
        .next_bit  (sr_next_bit),
        .parity    (sr_parity)
    );

    // sdo_d is the line level for the state being entered, so sdo stays registered.
    always_comb begin
        state_d = state_q;
        sdo_d   = sdo_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                sdo_d = LINE_IDLE;
                if (accept) begin
                    state_d = ST_START;
                    sdo_d   = ~LINE_IDLE;
                end
            end
            ST_START: begin
                if (period_end) begin
                    state_d = ST_DATA;
                    sdo_d   = sr_bit;
                end
            end
            ST_DATA: begin
                if (period_end) begin
                    if (!last_bit) begin
                        sdo_d = sr_next_bit;
                    end else if (mode_q[MODE_PARITY]) begin
                        state_d = ST_PARITY;
                        sdo_d   = sr_parity;
                    end else begin
                        state_d = ST_STOP;
                        sdo_d   = LINE_IDLE;
                    end
                end
            end
            ST_PARITY: begin
                if (period_end) begin
                    state_d = ST_STOP;
                    sdo_d   = LINE_IDLE;
                end
            end
            ST_STOP: begin
                if (period_end) begin
                    state_d = ST_IDLE;
                    sdo_d   = LINE_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                sdo_d   = LINE_IDLE;
            end
        endcase
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            sdo_q    <= LINE_IDLE;
            done_q   <= 1'b0;
            shadow_q <= '0;
            mode_q   <= 2'b00;
            cnt_q    <= '0;
        end else begin
            state_q <= state_d;
            sdo_q   <= sdo_d;
            done_q  <= done_d;
            if (accept) begin
                shadow_q <= tx.tx_data;
                mode_q   <= tx.tx_mode;
                cnt_q    <= '0;
            end else if (shift_en) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign tx.tx_ready = (state_q == ST_IDLE);
    assign tx.busy     = (state_q != ST_IDLE);
    assign tx.sdo      = sdo_q;
    assign tx.done     = done_q;
    assign tx.shadow   = shadow_q;

endmodule
